// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access sizes, FSM states,
// writeback select codes and the MEM/WB control payload.
package mem_pkg;

  typedef enum logic [1:0] {
    LS_BYTE   = 2'b00,
    LS_HALF   = 2'b01,
    LS_WORD   = 2'b10,
    LS_DOUBLE = 2'b11
  } ls_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  // Control part of the MEM/WB entry; data fields are width-parameterised in the top.
  typedef struct packed {
    logic       write_en;
    logic [1:0] sel;
    logic       misalign;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational lane logic: aligned address, byte enables, store lane shift,
// load lane extraction/extension and misalign detection.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (enables misalign detection).
module load_store_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_W       = XLEN / 8,
  parameter int unsigned OFF_W      = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]       addr,
  input  logic [1:0]            ls_type,
  input  logic                  ls_unsigned,
  input  logic [XLEN-1:0]       store_data,
  input  logic [XLEN-1:0]       rdata,
  output logic [ADDR_WIDTH-1:0] req_addr_c,
  output logic [XLEN-1:0]       wdata_c,
  output logic [BE_W-1:0]       be_c,
  output logic [XLEN-1:0]       load_data_c,
  output logic                  misalign_c
);

  ls_type_e              eff_type;
  logic [OFF_W-1:0]      off_raw;
  logic [OFF_W-1:0]      low_mask;
  logic [OFF_W-1:0]      off;
  logic [OFF_W+2:0]      bit_sh;
  logic [7:0]            base_be;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       lo_mask;
  logic                  sign_bit;
  logic [ADDR_WIDTH-1:0] full_addr;

  // Size decode; doubles collapse to words on a 32-bit datapath.
  always_comb begin
    eff_type = ls_type_e'(ls_type);
    if (XLEN == 32 && eff_type == LS_DOUBLE) eff_type = LS_WORD;
  end

  // Offset within the lane, truncated to natural alignment of the access size.
  assign off_raw  = addr[OFF_W-1:0];
  assign low_mask = (OFF_W'(1) << eff_type) - OFF_W'(1);
  assign off      = off_raw & ~low_mask;
  assign bit_sh   = {off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = |(off_raw & low_mask);
`else
  assign misalign_c = 1'b0;
`endif

  assign full_addr  = ADDR_WIDTH'(addr);
  assign req_addr_c = {full_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};

  // Per-size byte mask, lane mask and extension sign bit.
  always_comb begin
    base_be  = 8'h01;
    lo_mask  = XLEN'(8'hFF);
    sign_bit = shifted[7];
    case (eff_type)
      LS_HALF: begin
        base_be  = 8'h03;
        lo_mask  = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      LS_WORD: begin
        base_be  = 8'h0F;
        lo_mask  = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      LS_DOUBLE: begin
        base_be  = 8'hFF;
        lo_mask  = '1;
        sign_bit = 1'b0;
      end
      default: ;
    endcase
  end

  assign be_c        = BE_W'(base_be) << off;
  assign wdata_c     = store_data << bit_sh;
  assign shifted     = rdata >> bit_sh;
  assign load_data_c = (shifted & lo_mask) | ((!ls_unsigned && sign_bit) ? ~lo_mask : '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage with valid/ready request and response handshake; stalls
// upstream while an access is outstanding and registers the MEM/WB entry.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses fault in 1 cycle).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned BE_W       = XLEN / 8,
  parameter int unsigned OFF_W      = $clog2(XLEN / 8)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_BITS-1:0]   in_rd,
  input  logic                  in_write_en,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_ls_type,
  input  logic                  in_ls_unsigned,
  input  logic [1:0]            in_wb_sel,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [XLEN-1:0]       in_return_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [XLEN-1:0]       req_wdata,
  output logic [BE_W-1:0]       req_be,
  input  logic                  rsp_valid,
  input  logic [XLEN-1:0]       rsp_rdata,
  output logic                  wb_valid,
  output logic [REG_BITS-1:0]   wb_rd,
  output logic                  wb_write_en,
  output logic [XLEN-1:0]       wb_alu_out,
  output logic [XLEN-1:0]       wb_load_data,
  output logic [XLEN-1:0]       wb_return_pc,
  output logic [1:0]            wb_sel,
  output logic                  wb_misalign
);

  state_e              state_q, state_d;
  logic                capture, done_idle, done_hold;
  logic                in_is_mem, in_fault;

  logic [REG_BITS-1:0] hold_rd;
  logic                hold_write_en, hold_mem_write, hold_ls_unsigned;
  logic [1:0]          hold_ls_type, hold_wb_sel;
  logic [XLEN-1:0]     hold_alu_out, hold_return_pc;

  wb_ctrl_t            wb_ctrl_q;

  logic                  sel_in;
  logic [XLEN-1:0]       a_addr;
  logic [1:0]            a_type;
  logic                  a_uns;
  logic [ADDR_WIDTH-1:0] req_addr_c;
  logic [XLEN-1:0]       wdata_c, load_data_c;
  logic [BE_W-1:0]       be_c;
  logic                  misalign_c;

  // Lane logic sees the incoming instruction in IDLE and the held one otherwise.
  assign sel_in    = (state_q == IDLE);
  assign a_addr    = sel_in ? in_alu_out     : hold_alu_out;
  assign a_type    = sel_in ? in_ls_type     : hold_ls_type;
  assign a_uns     = sel_in ? in_ls_unsigned : hold_ls_unsigned;
  assign in_is_mem = in_mem_read | in_mem_write;
  assign in_fault  = in_is_mem & misalign_c;

  load_store_align #(
    .XLEN       (XLEN),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BE_W       (BE_W),
    .OFF_W      (OFF_W)
  ) u_align (
    .addr        (a_addr),
    .ls_type     (a_type),
    .ls_unsigned (a_uns),
    .store_data  (in_store_data),
    .rdata       (rsp_rdata),
    .req_addr_c  (req_addr_c),
    .wdata_c     (wdata_c),
    .be_c        (be_c),
    .load_data_c (load_data_c),
    .misalign_c  (misalign_c)
  );

  assign in_ready  = (state_q == IDLE);
  assign req_valid = (state_q == REQ);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and completion strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    done_idle = 1'b0;
    done_hold = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        capture = 1'b1;
        if (in_is_mem && !in_fault) state_d = REQ;
        else                        done_idle = 1'b1;
      end
      REQ: if (req_ready) begin
        if (hold_mem_write) begin
          done_hold = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = RESP;
        end
      end
      RESP: if (rsp_valid) begin
        done_hold = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding registers, request registers and the MEM/WB entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_rd          <= '0;
      hold_write_en    <= 1'b0;
      hold_mem_write   <= 1'b0;
      hold_ls_unsigned <= 1'b0;
      hold_ls_type     <= '0;
      hold_wb_sel      <= '0;
      hold_alu_out     <= '0;
      hold_return_pc   <= '0;
      req_we           <= 1'b0;
      req_addr         <= '0;
      req_wdata        <= '0;
      req_be           <= '0;
      wb_valid         <= 1'b0;
      wb_rd            <= '0;
      wb_ctrl_q        <= '0;
      wb_alu_out       <= '0;
      wb_load_data     <= '0;
      wb_return_pc     <= '0;
    end else begin
      wb_valid <= done_idle | done_hold;
      if (capture) begin
        hold_rd          <= in_rd;
        hold_write_en    <= in_write_en;
        hold_mem_write   <= in_mem_write;
        hold_ls_unsigned <= in_ls_unsigned;
        hold_ls_type     <= in_ls_type;
        hold_wb_sel      <= in_wb_sel;
        hold_alu_out     <= in_alu_out;
        hold_return_pc   <= in_return_pc;
        req_we           <= in_mem_write;
        req_addr         <= req_addr_c;
        req_wdata        <= wdata_c;
        req_be           <= be_c;
      end
      if (done_idle) begin
        wb_rd        <= in_rd;
        wb_ctrl_q    <= '{write_en: in_write_en & ~in_fault, sel: in_wb_sel, misalign: in_fault};
        wb_alu_out   <= in_alu_out;
        wb_load_data <= '0;
        wb_return_pc <= in_return_pc;
      end else if (done_hold) begin
        wb_rd        <= hold_rd;
        wb_ctrl_q    <= '{write_en: hold_write_en, sel: hold_wb_sel, misalign: 1'b0};
        wb_alu_out   <= hold_alu_out;
        wb_load_data <= (state_q == RESP) ? load_data_c : '0;
        wb_return_pc <= hold_return_pc;
      end
    end
  end

  assign wb_write_en = wb_ctrl_q.write_en;
  assign wb_sel      = wb_ctrl_q.sel;
  assign wb_misalign = wb_ctrl_q.misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=32).
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk, rstn;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic        in_write_en, in_mem_read, in_mem_write;
  logic [1:0]  in_ls_type;
  logic        in_ls_unsigned;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_out, in_store_data, in_return_pc;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_write_en;
  logic [31:0] wb_alu_out, wb_load_data, wb_return_pc;
  logic [1:0]  wb_sel;
  logic        wb_misalign;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_write_en(in_write_en),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_ls_type(in_ls_type),
    .in_ls_unsigned(in_ls_unsigned), .in_wb_sel(in_wb_sel), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data), .in_return_pc(in_return_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_write_en(wb_write_en), .wb_alu_out(wb_alu_out),
    .wb_load_data(wb_load_data), .wb_return_pc(wb_return_pc), .wb_sel(wb_sel),
    .wb_misalign(wb_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic rd_mem, input logic wr_mem,
                       input logic [1:0] ls, input logic uns, input logic [31:0] addr,
                       input logic [31:0] sdata);
    in_valid       = 1'b1;
    in_rd          = rd;
    in_write_en    = 1'b1;
    in_mem_read    = rd_mem;
    in_mem_write   = wr_mem;
    in_ls_type     = ls;
    in_ls_unsigned = uns;
    in_wb_sel      = rd_mem ? WB_SEL_MEM : WB_SEL_ALU;
    in_alu_out     = addr;
    in_store_data  = sdata;
    in_return_pc   = addr + 32'd4;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_alu_out    = 32'hFFFF_FFFC;
    in_store_data = 32'h5A5A_5A5A;
  endtask

  task automatic do_store(input string tag, input logic [1:0] ls, input logic [31:0] addr,
                          input logic [31:0] sdata, input int wait_cyc, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(negedge clk);
    issue(5'd2, 1'b0, 1'b1, ls, 1'b0, addr, sdata);
    req_ready = 1'b0;
    @(negedge clk);
    idle_in();
    check({tag, "_req_valid"}, req_valid, 1'b1);
    check({tag, "_req_addr"}, req_addr, exp_addr);
    check({tag, "_req_be"}, req_be, exp_be);
    check({tag, "_req_wdata"}, req_wdata, exp_wdata);
    check({tag, "_req_we"}, req_we, 1'b1);
    check({tag, "_stall"}, in_ready, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check({tag, "_hold_addr"}, req_addr, exp_addr);
      check({tag, "_hold_be"}, req_be, exp_be);
      check({tag, "_hold_wdata"}, req_wdata, exp_wdata);
      check({tag, "_hold_valid"}, req_valid, 1'b1);
      check({tag, "_no_wb"}, wb_valid, 1'b0);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check({tag, "_wb_valid"}, wb_valid, 1'b1);
    check({tag, "_wb_load"}, wb_load_data, 32'h0);
    check({tag, "_wb_alu"}, wb_alu_out, addr);
    check({tag, "_req_drop"}, req_valid, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b1);
    @(negedge clk);
    check({tag, "_bubble"}, wb_valid, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] ls, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata, input int rsp_delay,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    @(negedge clk);
    issue(5'd5, 1'b1, 1'b0, ls, uns, addr, 32'h0);
    req_ready = 1'b1;
    @(negedge clk);
    idle_in();
    check({tag, "_req_valid"}, req_valid, 1'b1);
    check({tag, "_req_addr"}, req_addr, exp_addr);
    check({tag, "_req_be"}, req_be, exp_be);
    check({tag, "_req_we"}, req_we, 1'b0);
    check({tag, "_stall"}, in_ready, 1'b0);
    @(negedge clk);
    req_ready = 1'b0;
    check({tag, "_resp_wait"}, req_valid, 1'b0);
    check({tag, "_resp_stall"}, in_ready, 1'b0);
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      check({tag, "_wait_stall"}, in_ready, 1'b0);
      check({tag, "_wait_no_wb"}, wb_valid, 1'b0);
    end
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_rdata = 32'hDEAD_0000;
    check({tag, "_wb_valid"}, wb_valid, 1'b1);
    check({tag, "_wb_load"}, wb_load_data, exp_data);
    check({tag, "_wb_rd"}, wb_rd, 5'd5);
    check({tag, "_wb_we"}, wb_write_en, 1'b1);
    check({tag, "_wb_sel"}, wb_sel, WB_SEL_MEM);
    check({tag, "_wb_mis"}, wb_misalign, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b1);
    @(negedge clk);
    check({tag, "_bubble"}, wb_valid, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    idle_in();
    in_rd = '0; in_write_en = 1'b0; in_ls_type = '0; in_ls_unsigned = 1'b0;
    in_wb_sel = '0; in_return_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1'b1);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_alu", wb_alu_out, 32'h0);
    check("rst_wb_load", wb_load_data, 32'h0);
    rstn = 1'b1;

    // ALU op retires one cycle later without stalling.
    @(negedge clk);
    issue(5'd3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0);
    in_return_pc = 32'h40;
    check("alu_ready0", in_ready, 1'b1);
    @(negedge clk);
    idle_in();
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_alu", wb_alu_out, 32'h1234);
    check("alu_wb_load", wb_load_data, 32'h0);
    check("alu_wb_rd", wb_rd, 5'd3);
    check("alu_wb_pc", wb_return_pc, 32'h40);
    check("alu_wb_we", wb_write_en, 1'b1);
    check("alu_ready1", in_ready, 1'b1);
    check("alu_no_req", req_valid, 1'b0);
    @(negedge clk);
    check("alu_bubble", wb_valid, 1'b0);
    check("alu_ready2", in_ready, 1'b1);

    do_store("sb", 2'b00, 32'h103, 32'h1234_56AB, 1, 32'h100, 4'b1000, 32'hAB00_0000);
    do_store("sh", 2'b01, 32'h202, 32'h0000_BEEF, 0, 32'h200, 4'b1100, 32'hBEEF_0000);
    do_store("sw", 2'b10, 32'h304, 32'hCAFE_1234, 2, 32'h304, 4'b1111, 32'hCAFE_1234);

    do_load("lh",  2'b01, 1'b0, 32'h102, 32'h8001_0000, 1, 32'h100, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 2'b01, 1'b1, 32'h102, 32'h8001_0000, 1, 32'h100, 4'b1100, 32'h0000_8001);
    do_load("lb",  2'b00, 1'b0, 32'h103, 32'h8001_0000, 0, 32'h100, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 2'b00, 1'b1, 32'h101, 32'h0000_F700, 0, 32'h100, 4'b0010, 32'h0000_00F7);
    do_load("ld32", 2'b11, 1'b0, 32'h104, 32'h8765_4321, 0, 32'h104, 4'b1111, 32'h8765_4321);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    issue(5'd9, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    idle_in();
    check("mis_no_req", req_valid, 1'b0);
    check("mis_wb_valid", wb_valid, 1'b1);
    check("mis_flag", wb_misalign, 1'b1);
    check("mis_we", wb_write_en, 1'b0);
    check("mis_ready", in_ready, 1'b1);
    @(negedge clk);
    check("mis_bubble", wb_valid, 1'b0);
    check("mis_no_req2", req_valid, 1'b0);
`else
    do_load("lw_mis", 2'b10, 1'b0, 32'h101, 32'h1122_3344, 0, 32'h100, 4'hF, 32'h1122_3344);
`endif

    // Reset while waiting for a response; a late response must be ignored.
    @(negedge clk);
    issue(5'd4, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    req_ready = 1'b1;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    req_ready = 1'b0;
    check("rr_in_resp", in_ready, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("rr_req_valid", req_valid, 1'b0);
    check("rr_wb_valid", wb_valid, 1'b0);
    check("rr_wb_load", wb_load_data, 32'h0);
    check("rr_wb_alu", wb_alu_out, 32'h0);
    check("rr_wb_rd", wb_rd, 5'd0);
    check("rr_ready", in_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("rr_late_wb", wb_valid, 1'b0);
    check("rr_late_req", req_valid, 1'b0);
    @(negedge clk);
    check("rr_late_wb2", wb_valid, 1'b0);

    // Load followed immediately by an ALU op held on the input.
    @(negedge clk);
    issue(5'd6, 1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0);
    req_ready = 1'b1;
    @(negedge clk);
    issue(5'd7, 1'b0, 1'b0, 2'b10, 1'b0, 32'h5555, 32'h0);
    check("b2b_stall1", in_ready, 1'b0);
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hCAFE_F00D;
    check("b2b_stall2", in_ready, 1'b0);
    check("b2b_no_wb", wb_valid, 1'b0);
    @(negedge clk);
    rsp_valid = 1'b0;
    check("b2b_ld_valid", wb_valid, 1'b1);
    check("b2b_ld_rd", wb_rd, 5'd6);
    check("b2b_ld_data", wb_load_data, 32'hCAFE_F00D);
    check("b2b_ready", in_ready, 1'b1);
    @(negedge clk);
    idle_in();
    check("b2b_alu_valid", wb_valid, 1'b1);
    check("b2b_alu_rd", wb_rd, 5'd7);
    check("b2b_alu_out", wb_alu_out, 32'h5555);
    check("b2b_alu_load", wb_load_data, 32'h0);
    @(negedge clk);
    check("b2b_bubble", wb_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
